// File: rtl/lbs_arbiter_if.sv
// Local-bus arbiter bundle: two requester ports plus the shared slave port.
// The slave modport is the arbiter's view; the master modport is the requesters-and-slave side.
interface lbs_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_ack;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_ack;
    logic [DW-1:0] m1_rdata;

    logic [AW-1:0] lbs_addr;
    logic [DW-1:0] lbs_din;
    logic          lbs_we;
    logic          lbs_re;
    logic [DW-1:0] lbs_dout;
    logic          busy;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  lbs_dout,
        output m0_ack, m0_rdata, m1_ack, m1_rdata,
        output lbs_addr, lbs_din, lbs_we, lbs_re, busy
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output lbs_dout,
        input  m0_ack, m0_rdata, m1_ack, m1_rdata,
        input  lbs_addr, lbs_din, lbs_we, lbs_re, busy
    );
endinterface

// File: rtl/lbs_arbiter.sv
// Round-robin arbiter sharing the datapath local-bus slave between the AXI4-lite
// bridge (port 0) and the configuration sequencer (port 1); one access at a time.
module lbs_arbiter #(
    parameter int U_DLY  = 1,
    parameter int AW     = 16,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic         axi4_lite_clk,
    input  logic         rst_n,
    lbs_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state;
    logic          last_grant;
    logic          gnt;
    logic          lat_we;
    logic [2:0]    cnt;

    logic          pick;
    logic          pick_we;
    logic [AW-1:0] pick_addr;
    logic [DW-1:0] pick_wdata;

    if (RD_LAT < 1 || RD_LAT > 7 || U_DLY < 0) begin : g_bad_param
        $fatal(1, "lbs_arbiter: RD_LAT must be 1..7 and U_DLY non-negative");
    end

    // On a tie the port that did not win last time is served.
    assign pick       = (bus.m0_req && bus.m1_req) ? ~last_grant : bus.m1_req;
    assign pick_we    = pick ? bus.m1_we    : bus.m0_we;
    assign pick_addr  = pick ? bus.m1_addr  : bus.m0_addr;
    assign pick_wdata = pick ? bus.m1_wdata : bus.m0_wdata;

    always_ff @(posedge axi4_lite_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            gnt          <= 1'b0;
            lat_we       <= 1'b0;
            cnt          <= 3'd0;
            bus.lbs_addr <= '0;
            bus.lbs_din  <= '0;
            bus.lbs_we   <= 1'b0;
            bus.lbs_re   <= 1'b0;
            bus.busy     <= 1'b0;
            bus.m0_ack   <= 1'b0;
            bus.m1_ack   <= 1'b0;
            bus.m0_rdata <= '0;
            bus.m1_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.m0_req || bus.m1_req) begin
                        gnt          <= pick;
                        last_grant   <= pick;
                        lat_we       <= pick_we;
                        bus.lbs_addr <= pick_addr;
                        bus.lbs_din  <= pick_wdata;
                        bus.lbs_we   <= pick_we;
                        bus.lbs_re   <= ~pick_we;
                        bus.busy     <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.lbs_we <= 1'b0;
                    bus.lbs_re <= 1'b0;
                    if (lat_we) begin
                        bus.m0_ack <= ~gnt;
                        bus.m1_ack <= gnt;
                        state      <= DONE;
                    end else begin
                        cnt   <= 3'(RD_LAT);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    // Slave data is valid in the last counted cycle.
                    if (cnt == 3'd1) begin
                        if (gnt) bus.m1_rdata <= bus.lbs_dout;
                        else     bus.m0_rdata <= bus.lbs_dout;
                        bus.m0_ack <= ~gnt;
                        bus.m1_ack <= gnt;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    bus.m0_ack <= 1'b0;
                    bus.m1_ack <= 1'b0;
                    bus.busy   <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lbs_arbiter.sv
// Bench for lbs_arbiter: directed protocol steps on an RD_LAT=3 instance, then
// randomized two-port traffic on an RD_LAT=2 instance against a last-write-wins memory model.
module tb_lbs_arbiter;
    localparam int AW = 16;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    lbs_arbiter_if #(.AW(AW), .DW(DW)) ia ();
    lbs_arbiter_if #(.AW(AW), .DW(DW)) ib ();

    lbs_arbiter #(.U_DLY(1), .AW(AW), .DW(DW), .RD_LAT(3)) dut_a (
        .axi4_lite_clk(clk), .rst_n(rst_n), .bus(ia));
    lbs_arbiter #(.U_DLY(1), .AW(AW), .DW(DW), .RD_LAT(2)) dut_b (
        .axi4_lite_clk(clk), .rst_n(rst_n), .bus(ib));

    // Slave RAMs: data for a read strobe appears RD_LAT cycles after the strobe cycle.
    logic [DW-1:0] mem_a [0:255];
    logic [DW-1:0] mem_b [0:255];
    logic [DW-1:0] sh_a  [0:2];
    logic [DW-1:0] sh_b  [0:1];

    always @(posedge clk) begin
        sh_a[0] <= ia.lbs_re ? mem_a[ia.lbs_addr[7:0]] : '0;
        sh_a[1] <= sh_a[0];
        sh_a[2] <= sh_a[1];
        sh_b[0] <= ib.lbs_re ? mem_b[ib.lbs_addr[7:0]] : '0;
        sh_b[1] <= sh_b[0];
        if (ia.lbs_we) mem_a[ia.lbs_addr[7:0]] = ia.lbs_din;
        if (ib.lbs_we) mem_b[ib.lbs_addr[7:0]] = ib.lbs_din;
    end
    assign ia.lbs_dout = sh_a[2];
    assign ib.lbs_dout = sh_b[1];

    // Reference: expected content of each random-test address, in access order.
    logic [DW-1:0] ref_mem [0:7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("strobe_excl_a", ia.lbs_we & ia.lbs_re, 1'b0);
            chk("ack_excl_a",    ia.m0_ack & ia.m1_ack, 1'b0);
            chk("strobe_excl_b", ib.lbs_we & ib.lbs_re, 1'b0);
            chk("ack_excl_b",    ib.m0_ack & ib.m1_ack, 1'b0);
        end
    end

    task automatic drive_a(input bit p, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input logic req);
        if (!p) begin
            ia.m0_req = req; ia.m0_we = we; ia.m0_addr = addr; ia.m0_wdata = wd;
        end else begin
            ia.m1_req = req; ia.m1_we = we; ia.m1_addr = addr; ia.m1_wdata = wd;
        end
    endtask

    task automatic drive_b(input bit p, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input logic req);
        if (!p) begin
            ib.m0_req = req; ib.m0_we = we; ib.m0_addr = addr; ib.m0_wdata = wd;
        end else begin
            ib.m1_req = req; ib.m1_we = we; ib.m1_addr = addr; ib.m1_wdata = wd;
        end
    endtask

    task automatic check_idle_a(input string tag);
        chk({tag, "_m0_ack"},   ia.m0_ack,   1'b0);
        chk({tag, "_m1_ack"},   ia.m1_ack,   1'b0);
        chk({tag, "_m0_rdata"}, ia.m0_rdata, '0);
        chk({tag, "_m1_rdata"}, ia.m1_rdata, '0);
        chk({tag, "_lbs_addr"}, ia.lbs_addr, '0);
        chk({tag, "_lbs_din"},  ia.lbs_din,  '0);
        chk({tag, "_lbs_we"},   ia.lbs_we,   1'b0);
        chk({tag, "_lbs_re"},   ia.lbs_re,   1'b0);
        chk({tag, "_busy"},     ia.busy,     1'b0);
    endtask

    // Complete one access on dut_a and return the port's rdata seen with its ack.
    task automatic do_a(input bit p, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, output logic [DW-1:0] rd);
        logic got;
        got = 1'b0;
        drive_a(p, we, addr, wd, 1'b1);
        for (int c = 0; c < 20 && !got; c++) begin
            step();
            got = p ? ia.m1_ack : ia.m0_ack;
        end
        chk("do_a_ack", got, 1'b1);
        rd = p ? ia.m1_rdata : ia.m0_rdata;
        step();
        drive_a(p, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic port_b_run(input bit p, input int n);
        logic          we;
        logic [2:0]    ai;
        logic [DW-1:0] wd;
        logic          got;
        for (int i = 0; i < n; i++) begin
            we = 1'($urandom_range(0, 1));
            ai = 3'($urandom_range(0, 7));
            wd = $urandom;
            drive_b(p, we, {11'd0, ai, 2'b00}, wd, 1'b1);
            got = 1'b0;
            // Worst case is one foreign access plus this one.
            for (int c = 0; c < 24 && !got; c++) begin
                step();
                got = p ? ib.m1_ack : ib.m0_ack;
            end
            chk(p ? "rand_ack_m1" : "rand_ack_m0", got, 1'b1);
            if (got) begin
                if (we) ref_mem[ai] = wd;
                else    chk(p ? "rand_rdata_m1" : "rand_rdata_m0",
                            p ? ib.m1_rdata : ib.m0_rdata, ref_mem[ai]);
            end
            step();
            if ($urandom_range(0, 1) == 1) begin
                drive_b(p, 1'b0, '0, '0, 1'b0);
                repeat ($urandom_range(0, 3)) step();
            end
        end
        drive_b(p, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic          exp_port;
        logic          got;
        logic          seen_port;

        drive_a(0, 1'b0, '0, '0, 1'b0);
        drive_a(1, 1'b0, '0, '0, 1'b0);
        drive_b(0, 1'b0, '0, '0, 1'b0);
        drive_b(1, 1'b0, '0, '0, 1'b0);
        repeat (3) step();
        check_idle_a("reset");
        rst_n = 1'b1;
        step();

        // Single write from m0.
        drive_a(0, 1'b1, 16'h0010, 32'hA5A5_0001, 1'b1);
        chk("wr_c0_busy", ia.busy, 1'b0);
        step();
        chk("wr_c1_we",   ia.lbs_we,   1'b1);
        chk("wr_c1_re",   ia.lbs_re,   1'b0);
        chk("wr_c1_addr", ia.lbs_addr, 16'h0010);
        chk("wr_c1_din",  ia.lbs_din,  32'hA5A5_0001);
        chk("wr_c1_busy", ia.busy,     1'b1);
        chk("wr_c1_ack",  ia.m0_ack,   1'b0);
        step();
        chk("wr_c2_ack",  ia.m0_ack, 1'b1);
        chk("wr_c2_ack1", ia.m1_ack, 1'b0);
        chk("wr_c2_we",   ia.lbs_we, 1'b0);
        chk("wr_c2_busy", ia.busy,   1'b1);
        step();
        drive_a(0, 1'b0, '0, '0, 1'b0);
        chk("wr_c3_ack",  ia.m0_ack, 1'b0);
        chk("wr_c3_busy", ia.busy,   1'b0);

        // Single read from m1 with a three-cycle slave.
        do_a(0, 1'b1, 16'h0200, 32'hDEAD_BEEF, rd);
        drive_a(1, 1'b0, 16'h0200, '0, 1'b1);
        step();
        chk("rd_c1_re",   ia.lbs_re,   1'b1);
        chk("rd_c1_we",   ia.lbs_we,   1'b0);
        chk("rd_c1_addr", ia.lbs_addr, 16'h0200);
        for (int c = 2; c <= 4; c++) begin
            step();
            chk("rd_wait_ack", ia.m1_ack, 1'b0);
            chk("rd_wait_re",  ia.lbs_re, 1'b0);
        end
        step();
        chk("rd_c5_ack",   ia.m1_ack,   1'b1);
        chk("rd_c5_rdata", ia.m1_rdata, 32'hDEAD_BEEF);
        step();
        drive_a(1, 1'b0, '0, '0, 1'b0);
        do_a(1, 1'b1, 16'h0204, 32'h0000_1234, rd);
        chk("rd_hold_rdata", rd, 32'hDEAD_BEEF);

        // Simultaneous requests out of reset, both held for four accesses.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        drive_a(0, 1'b1, 16'h0020, 32'h0000_1000, 1'b1);
        drive_a(1, 1'b1, 16'h0024, 32'h0000_2000, 1'b1);
        exp_port = 1'b0;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            seen_port = 1'b0;
            for (int c = 0; c < 12 && !got; c++) begin
                step();
                got       = ia.m0_ack | ia.m1_ack;
                seen_port = ia.m1_ack;
            end
            chk("rr_ack_seen", got, 1'b1);
            chk("rr_order",    seen_port, exp_port);
            exp_port = ~exp_port;
        end
        drive_a(0, 1'b0, '0, '0, 1'b0);
        drive_a(1, 1'b0, '0, '0, 1'b0);
        repeat (2) step();
        chk("rr_idle_busy", ia.busy, 1'b0);

        // m0 reissues a write at the edge of its ack.
        drive_a(0, 1'b1, 16'h0030, 32'h0000_0030, 1'b1);
        step();
        chk("b2b_c1_we", ia.lbs_we, 1'b1);
        step();
        chk("b2b_c2_ack", ia.m0_ack, 1'b1);
        chk("b2b_c2_we",  ia.lbs_we, 1'b0);
        step();
        drive_a(0, 1'b1, 16'h0034, 32'h0000_0034, 1'b1);
        chk("b2b_c3_we", ia.lbs_we, 1'b0);
        step();
        chk("b2b_c4_we",   ia.lbs_we,   1'b1);
        chk("b2b_c4_addr", ia.lbs_addr, 16'h0034);
        step();
        chk("b2b_c5_ack", ia.m0_ack, 1'b1);
        step();
        drive_a(0, 1'b0, '0, '0, 1'b0);

        // Reset while an m1 read is waiting for the slave.
        drive_a(1, 1'b0, 16'h0010, '0, 1'b1);
        repeat (3) step();
        chk("rst_mid_busy_before", ia.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_idle_a("rst_mid");
        drive_a(1, 1'b0, '0, '0, 1'b0);
        repeat (2) begin
            step();
            chk("rst_mid_no_ack", ia.m1_ack, 1'b0);
        end
        rst_n = 1'b1;
        step();
        drive_a(1, 1'b0, 16'h0010, '0, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            step();
            chk("rst_rd_no_ack", ia.m1_ack, 1'b0);
        end
        step();
        chk("rst_rd_ack",   ia.m1_ack,   1'b1);
        chk("rst_rd_rdata", ia.m1_rdata, 32'hA5A5_0001);
        step();
        drive_a(1, 1'b0, '0, '0, 1'b0);

        // Randomized traffic on the RD_LAT=2 instance; every address is written first.
        for (int i = 0; i < 8; i++) begin
            logic [DW-1:0] wd;
            logic          ok;
            wd = $urandom;
            drive_b(0, 1'b1, AW'(i * 4), wd, 1'b1);
            ok = 1'b0;
            for (int c = 0; c < 20 && !ok; c++) begin
                step();
                ok = ib.m0_ack;
            end
            chk("preload_ack", ok, 1'b1);
            ref_mem[i] = wd;
            step();
            drive_b(0, 1'b0, '0, '0, 1'b0);
        end
        fork
            port_b_run(1'b0, 40);
            port_b_run(1'b1, 40);
        join
        repeat (3) step();
        chk("rand_end_busy", ib.busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lbs_arbiter.md
# lbs_arbiter

Two-port arbiter that shares the single local-bus slave port of the convolution datapath (lbs_addr/lbs_din/lbs_we/lbs_re/lbs_dout) between two requesters: port 0 (AXI4-lite CPU bridge) and port 1 (internal configuration sequencer). It serializes accesses with round-robin arbitration. Each access produces a single-cycle lbs_we or lbs_re strobe. Read data is returned after a fixed slave latency. It sits between the AXI4-lite bridge and the datapath register bank, entirely in the axi4_lite_clk domain.

## Interface
- U_DLY, 1, simulation delay on registered assignments
- AW, 16, local-bus address width
- DW, 32, local-bus data width
- RD_LAT, 1, cycles from the lbs_re cycle to valid lbs_dout; legal range 1..7
- axi4_lite_clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- m0_req / m1_req  in  1  access request; held high until ack
- m0_we / m1_we  in  1  1 = write, 0 = read; stable while req high
- m0_addr / m1_addr  in  AW  address; stable while req high
- m0_wdata / m1_wdata  in  DW  write data; stable while req high
- m0_ack / m1_ack  out  1  one-cycle completion pulse
- m0_rdata / m1_rdata  out  DW  read data; valid with ack, held until that port's next read ack
- lbs_addr  out  AW  shared slave address
- lbs_din  out  DW  shared slave write data
- lbs_we  out  1  one-cycle write strobe
- lbs_re  out  1  one-cycle read strobe
- lbs_dout  in  DW  slave read data
- busy  out  1  high whenever FSM not IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: sample m0_req/m1_req.
  - One request: grant it.
  - Both requests: grant the port not in last_grant.
  - On grant: latch we/addr/wdata into lbs_addr/lbs_din, update last_grant, go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (1 cycle): lbs_we = latched we, lbs_re = ~latched we.
  - Write: go to DONE.
  - Read: go to WAIT with counter = RD_LAT.
- WAIT: decrement counter each cycle. At counter==1, capture lbs_dout into the granted port's rdata register and go to DONE.
- DONE (1 cycle): granted port's ack = 1, then go to IDLE.
- Requester rule: drop req at the edge where ack is sampled high, or present a new request.
  - IDLE follows DONE, so a back-to-back request from the same port is legal.
  - If the other port is waiting, round-robin grants the other port first.
- last_grant resets to 1, so port 0 wins the first tie.
- lbs_addr/lbs_din hold their last value outside ISSUE. lbs_we/lbs_re are 0 outside ISSUE.
- Only one of lbs_we/lbs_re is ever high. At most one ack is high per cycle.
- A request arriving while the FSM is not IDLE waits; it is never dropped.
- req deasserted before ack (protocol violation): the in-flight access still completes and ack still pulses.

## Timing
- Reset values: all outputs 0; FSM IDLE; last_grant = 1; rdata registers 0.
- Reset asserted mid-access: immediate return to the reset values. The in-flight access is abandoned with no ack. A strobe already issued is not retracted.
- Cycle numbering: req high in cycle 0 (sampled at the end of cycle 0).
- Write: lbs_we in cycle 1; ack in cycle 2.
  - Minimum spacing of back-to-back writes from one port: 3 cycles.
- Read: lbs_re in cycle 1; lbs_dout captured at the end of cycle 1+RD_LAT; ack and rdata in cycle 2+RD_LAT.
  - Example: RD_LAT=1 gives ack in cycle 3.
- Throughput: one access per 3 cycles (write) or 3+RD_LAT cycles (read).
- Worst-case wait for a port is one foreign access plus its own.

## Test plan
- Single write, m0, addr 0x0010, data 0xA5A5_0001 -> lbs_we high in cycle 1 with lbs_addr=0x0010 and lbs_din=0xA5A5_0001; m0_ack in cycle 2; busy high in cycles 1-2.
- Single read, m1, RD_LAT=3, slave returns 0xDEAD_BEEF three cycles after lbs_re -> lbs_re in cycle 1; m1_ack in cycle 5 with m1_rdata=0xDEAD_BEEF; value held through the following m1 write.
- Simultaneous m0 and m1 requests out of reset -> m0 granted first, then m1. With both held continuously for 4 accesses, the grant order is 0,1,0,1 and no ack overlaps.
- Back-to-back: m0 reissues a write at the edge of its ack while m1 is idle -> the second lbs_we falls exactly 3 cycles after the first.
- rst_n low during WAIT of a read -> no ack, all outputs 0. After release, a new m1 read completes normally.
- Randomized req/we/addr on both ports against a slave RAM model with RD_LAT=2 -> read data always matches the last write to that address; lbs_we and lbs_re are never high together.
